// File: rtl/board_io_conditioner.sv
// Board I/O conditioner: synchronised, debounced inputs with edge pulses,
// and glitch-free PWM dimming for LED outputs with period-aligned duty updates.
module board_io_conditioner #(
  parameter int              N_IN            = 7,
  parameter int              N_LED           = 4,
  parameter int              SYNC_STAGES     = 2,
  parameter int              DEBOUNCE_CYCLES = 100000,
  parameter int              CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int              PWM_W           = 8,
  parameter logic [N_IN-1:0] IN_RESET_VAL    = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_IN-1:0]        in_raw_i,
  output logic [N_IN-1:0]        in_level_o,
  output logic [N_IN-1:0]        in_rise_o,
  output logic [N_IN-1:0]        in_fall_o,
  input  logic [N_LED*PWM_W-1:0] led_duty_i,
  input  logic [N_LED-1:0]       led_en_i,
  output logic                   pwm_wrap_o,
  output logic [N_LED-1:0]       led_o
);

  localparam logic [CNT_W-1:0] DB_TC   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PWM_W-1:0] PWM_MAX = '1;

  logic [N_IN-1:0]  sync_q [SYNC_STAGES];
  logic [N_IN-1:0]  sync;
  logic [CNT_W-1:0] db_cnt [N_IN];

  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] pwm_nxt;
  logic [PWM_W-1:0] duty_sh  [N_LED];
  logic [PWM_W-1:0] duty_nxt [N_LED];
  logic             load_q;

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous pin levels.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= in_raw_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Per-channel debounce: a new level must persist DEBOUNCE_CYCLES cycles;
  // edge pulses are raised in the same cycle the level flips.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_IN; i++) db_cnt[i] <= '0;
      in_level_o <= IN_RESET_VAL;
      in_rise_o  <= '0;
      in_fall_o  <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        in_rise_o[i] <= 1'b0;
        in_fall_o[i] <= 1'b0;
        if (sync[i] == in_level_o[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_TC) begin
          in_level_o[i] <= sync[i];
          in_rise_o[i]  <= sync[i];
          in_fall_o[i]  <= ~sync[i];
          db_cnt[i]     <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Next counter value and next shadow duty; the shadow only reloads at the
  // period boundary (or right after reset) so a mid-period write cannot glitch.
  always_comb begin
    pwm_nxt = pwm_cnt + PWM_W'(1);
    for (int k = 0; k < N_LED; k++) begin
      duty_nxt[k] = duty_sh[k];
      if (load_q || (pwm_cnt == PWM_MAX)) duty_nxt[k] = led_duty_i[k*PWM_W +: PWM_W];
    end
  end

  // PWM counter, wrap pulse, duty shadows and registered LED drive.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_cnt    <= '0;
      pwm_wrap_o <= 1'b0;
      load_q     <= 1'b1;
      led_o      <= '0;
      for (int k = 0; k < N_LED; k++) duty_sh[k] <= '0;
    end else begin
      pwm_cnt    <= pwm_nxt;
      pwm_wrap_o <= (pwm_cnt == PWM_MAX);
      load_q     <= 1'b0;
      for (int k = 0; k < N_LED; k++) begin
        duty_sh[k] <= duty_nxt[k];
        // Full-scale duty is treated as constantly on so there is no dark cycle.
        led_o[k]   <= led_en_i[k] && (duty_nxt[k] != '0) &&
                      ((duty_nxt[k] == PWM_MAX) || (pwm_nxt < duty_nxt[k]));
      end
    end
  end

endmodule
